vending_machine_param: RTL and testbench

Parametrised next-generation vending controller. It generalises the fixed 4-item, 1000-won machine to N items with per-item prices, a configurable credit ceiling and per-item stock counters. It adds coin-by-coin change dispensing through a small FSM. It sits between the board switch/button debouncers and the LED/7-segment display logic, and reuses the team's existing 7-segment `decoder` module for its display outputs.

---
 rtl/vm_pkg.sv | 33 +++
 rtl/vending_machine_param_if.sv | 40 ++++
 rtl/decoder.sv | 25 ++
 rtl/vm_change_dispenser.sv | 76 +++++++
 rtl/vending_machine_param.sv | 155 +++++++++++++++
 tb/tb_vending_machine_param.sv | 347 ++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/vm_pkg.sv
// vm_pkg: coin values, coin bit positions and FSM state type shared by the
// vending controller and its change dispenser.
package vm_pkg;

   // Coin values in 100-won units
   localparam logic [3:0] C1000 = 4'd10;
   localparam logic [3:0] C500  = 4'd5;
   localparam logic [3:0] C200  = 4'd2;
   localparam logic [3:0] C100  = 4'd1;

   // Bit position of each coin in the moneyin / change_coin vectors
   localparam int COIN_1000_IDX = 3;
   localparam int COIN_500_IDX  = 2;
   localparam int COIN_200_IDX  = 1;
   localparam int COIN_100_IDX  = 0;

   typedef enum logic {
      IDLE,
      CHANGE
   } vm_state_t;

   // Value of a one-hot coin vector; anything that is not a single coin is worth 0
   function automatic logic [3:0] coin_value(input logic [3:0] coin);
      logic [3:0] value;
      value = 4'd0;
      if (coin == 4'(1 << COIN_1000_IDX)) value = C1000;
      if (coin == 4'(1 << COIN_500_IDX))  value = C500;
      if (coin == 4'(1 << COIN_200_IDX))  value = C200;
      if (coin == 4'(1 << COIN_100_IDX))  value = C100;
      return value;
   endfunction

endpackage

// File: rtl/vending_machine_param_if.sv
// vending_machine_param_if: user-facing buttons/coins in, LEDs/display/vend out.
// The master side is the board (or bench), the slave side is the controller.
interface vending_machine_param_if #(
   parameter int N_ITEMS  = 4,
   parameter int CREDIT_W = 7
);
   logic [3:0]          moneyin;
   logic [N_ITEMS-1:0]  buy;
   logic                refund;
   logic                restock;

   logic [CREDIT_W-1:0] credit;
   logic [6:0]          seg_1000;
   logic [6:0]          seg_100;
   logic [6:0]          seg_10;
   logic [6:0]          seg_1;
   logic                moneyin_led;
   logic                coin_reject;
   logic [N_ITEMS-1:0]  buy_available_led;
   logic [N_ITEMS-1:0]  sold_out_led;
   logic [N_ITEMS-1:0]  vend;
   logic                buy_success_led;
   logic                buy_fail_led;
   logic [3:0]          change_coin;
   logic                refund_led;

   modport master (
      output moneyin, buy, refund, restock,
      input  credit, seg_1000, seg_100, seg_10, seg_1,
             moneyin_led, coin_reject, buy_available_led, sold_out_led,
             vend, buy_success_led, buy_fail_led, change_coin, refund_led
   );

   modport slave (
      input  moneyin, buy, refund, restock,
      output credit, seg_1000, seg_100, seg_10, seg_1,
             moneyin_led, coin_reject, buy_available_led, sold_out_led,
             vend, buy_success_led, buy_fail_led, change_coin, refund_led
   );
endinterface

// File: rtl/decoder.sv
// decoder: one BCD digit to an active-high 7-segment pattern {g,f,e,d,c,b,a}.
module decoder (
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   // Segment lookup; non-decimal codes blank the digit
   always_comb begin
      seg = 7'h00;
      case (digit)
         4'd0: seg = 7'h3F;
         4'd1: seg = 7'h06;
         4'd2: seg = 7'h5B;
         4'd3: seg = 7'h4F;
         4'd4: seg = 7'h66;
         4'd5: seg = 7'h6D;
         4'd6: seg = 7'h7D;
         4'd7: seg = 7'h07;
         4'd8: seg = 7'h7F;
         4'd9: seg = 7'h6F;
         default: seg = 7'h00;
      endcase
   end

endmodule

// File: rtl/vm_change_dispenser.sv
// vm_change_dispenser: owns the IDLE/CHANGE state and pays out the credit one
// greedy coin per cycle. The credit register itself lives in the top, which
// subtracts coin_amount every cycle the dispenser is paying.
module vm_change_dispenser
   import vm_pkg::*;
#(
   parameter int CREDIT_W = 7
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [CREDIT_W-1:0] credit,
   output logic                in_change,
   output logic                done,
   output logic [CREDIT_W-1:0] coin_amount,
   output logic [3:0]          change_coin
);

   localparam logic [CREDIT_W-1:0] V1000 = CREDIT_W'(C1000);
   localparam logic [CREDIT_W-1:0] V500  = CREDIT_W'(C500);
   localparam logic [CREDIT_W-1:0] V200  = CREDIT_W'(C200);
   localparam logic [CREDIT_W-1:0] V100  = CREDIT_W'(C100);

   vm_state_t  state;
   logic [3:0] sel_coin;

   // Largest coin that still fits in the remaining credit; nothing when credit is 0
   always_comb begin
      sel_coin    = '0;
      coin_amount = '0;
      if (credit >= V1000) begin
         sel_coin[COIN_1000_IDX] = 1'b1;
         coin_amount             = V1000;
      end else if (credit >= V500) begin
         sel_coin[COIN_500_IDX] = 1'b1;
         coin_amount            = V500;
      end else if (credit >= V200) begin
         sel_coin[COIN_200_IDX] = 1'b1;
         coin_amount            = V200;
      end else if (credit >= V100) begin
         sel_coin[COIN_100_IDX] = 1'b1;
         coin_amount            = V100;
      end
   end

   // State machine: leave CHANGE one cycle after the credit has been paid down to 0
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         change_coin <= '0;
      end else begin
         case (state)
            IDLE: begin
               change_coin <= '0;
               if (start) state <= CHANGE;
            end
            CHANGE: begin
               if (credit == '0) begin
                  state       <= IDLE;
                  change_coin <= '0;
               end else begin
                  change_coin <= sel_coin;
               end
            end
            default: begin
               state       <= IDLE;
               change_coin <= '0;
            end
         endcase
      end
   end

   assign in_change = (state == CHANGE);
   assign done      = in_change && (credit == '0);

endmodule

// File: rtl/vending_machine_param.sv
// vending_machine_param: N-item vending controller with per-item prices and
// stock, a credit ceiling, and coin-by-coin change through vm_change_dispenser.
module vending_machine_param
   import vm_pkg::*;
#(
   parameter int                          N_ITEMS    = 4,
   parameter int                          CREDIT_W   = 7,
   parameter int                          MAX_CREDIT = 10,
   parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES     = {7'd9, 7'd7, 7'd5, 7'd3},
   parameter int                          STOCK_W    = 4,
   parameter int                          INIT_STOCK = 5
) (
   input  logic                    clk,
   input  logic                    reset_n,
   vending_machine_param_if.slave  bus
);

   localparam int                  IDX_W  = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
   localparam logic [STOCK_W-1:0]  INIT_S = STOCK_W'(INIT_STOCK);
   localparam logic [CREDIT_W:0]   MAX_C  = (CREDIT_W+1)'(MAX_CREDIT);

   logic [CREDIT_W-1:0] credit_q;
   logic [STOCK_W-1:0]  stock_q [N_ITEMS];
   logic [CREDIT_W-1:0] price   [N_ITEMS];

   logic                moneyin_led_q;
   logic                coin_reject_q;
   logic [N_ITEMS-1:0]  vend_q;
   logic                buy_success_q;
   logic                buy_fail_q;

   logic [3:0]          coin_val;
   logic [CREDIT_W:0]   coin_sum;
   logic                coin_ok;
   logic [IDX_W-1:0]    buy_idx;
   logic                buy_ok;

   logic                start_change;
   logic                in_change;
   logic                change_done;
   logic [CREDIT_W-1:0] change_amount;
   logic [3:0]          change_coin;

   logic [N_ITEMS-1:0]  avail;
   logic [N_ITEMS-1:0]  sold;
   logic [3:0]          digit_1000;
   logic [3:0]          digit_100;

   // Per-item price slices and the level LEDs derived from registered state
   for (genvar i = 0; i < N_ITEMS; i++) begin : g_item
      assign price[i] = PRICES[i*CREDIT_W +: CREDIT_W];
      assign avail[i] = (credit_q >= price[i]) && (stock_q[i] != '0) && !in_change;
      assign sold[i]  = (stock_q[i] == '0);
   end

   // Coin acceptance: a single coin that keeps credit within the ceiling; the
   // sum is one bit wider so it cannot wrap
   always_comb begin
      coin_val = coin_value(bus.moneyin);
      coin_sum = {1'b0, credit_q} + (CREDIT_W+1)'(coin_val);
      coin_ok  = $onehot(bus.moneyin) && (coin_sum <= MAX_C);
   end

   // Purchase check: exactly one item requested, affordable and in stock
   always_comb begin
      buy_idx = '0;
      for (int i = 0; i < N_ITEMS; i++) begin
         if (bus.buy[i]) buy_idx = IDX_W'(i);
      end
      buy_ok = $onehot(bus.buy) && (credit_q >= price[buy_idx]) && (stock_q[buy_idx] != '0);
   end

   assign start_change = !in_change && bus.refund && (credit_q != '0);

   vm_change_dispenser #(
      .CREDIT_W (CREDIT_W)
   ) u_change (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start_change),
      .credit      (credit_q),
      .in_change   (in_change),
      .done        (change_done),
      .coin_amount (change_amount),
      .change_coin (change_coin)
   );

   // Credit, stock and one-cycle pulses; in IDLE only the highest-priority event
   // (refund > coin > buy > restock) is acted on, in CHANGE coins and buys bounce
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         credit_q      <= '0;
         moneyin_led_q <= 1'b0;
         coin_reject_q <= 1'b0;
         vend_q        <= '0;
         buy_success_q <= 1'b0;
         buy_fail_q    <= 1'b0;
         for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= INIT_S;
      end else begin
         moneyin_led_q <= 1'b0;
         coin_reject_q <= 1'b0;
         vend_q        <= '0;
         buy_success_q <= 1'b0;
         buy_fail_q    <= 1'b0;
         if (in_change) begin
            if (!change_done) credit_q <= credit_q - change_amount;
            if (|bus.moneyin) coin_reject_q <= 1'b1;
            if (|bus.buy)     buy_fail_q    <= 1'b1;
            if (bus.restock) begin
               for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= INIT_S;
            end
         end else if (bus.refund) begin
         end else if (|bus.moneyin) begin
            if (coin_ok) begin
               credit_q      <= coin_sum[CREDIT_W-1:0];
               moneyin_led_q <= 1'b1;
            end else begin
               coin_reject_q <= 1'b1;
            end
         end else if (|bus.buy) begin
            if (buy_ok) begin
               credit_q          <= credit_q - price[buy_idx];
               stock_q[buy_idx]  <= stock_q[buy_idx] - STOCK_W'(1);
               vend_q[buy_idx]   <= 1'b1;
               buy_success_q     <= 1'b1;
            end else begin
               buy_fail_q <= 1'b1;
            end
         end else if (bus.restock) begin
            for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= INIT_S;
         end
      end
   end

   // Credit in won is credit*100, so the two low display digits are always 0
   assign digit_1000 = 4'(credit_q / CREDIT_W'(10));
   assign digit_100  = 4'(credit_q % CREDIT_W'(10));

   decoder u_dec_1000 (.digit(digit_1000), .seg(bus.seg_1000));
   decoder u_dec_100  (.digit(digit_100),  .seg(bus.seg_100));
   decoder u_dec_10   (.digit(4'd0),       .seg(bus.seg_10));
   decoder u_dec_1    (.digit(4'd0),       .seg(bus.seg_1));

   assign bus.credit            = credit_q;
   assign bus.moneyin_led       = moneyin_led_q;
   assign bus.coin_reject       = coin_reject_q;
   assign bus.buy_available_led = avail;
   assign bus.sold_out_led      = sold;
   assign bus.vend              = vend_q;
   assign bus.buy_success_led   = buy_success_q;
   assign bus.buy_fail_led      = buy_fail_q;
   assign bus.change_coin       = change_coin;
   assign bus.refund_led        = in_change;

endmodule

// File: tb/tb_vending_machine_param.sv
// tb_vending_machine_param: directed and random stimulus; a behavioural model
// predicts every cycle's outputs into a scoreboard that a monitor drains.
module tb_vending_machine_param;

   localparam int N_ITEMS    = 4;
   localparam int CREDIT_W   = 7;
   localparam int MAX_CREDIT = 10;
   localparam int STOCK_W    = 4;
   localparam int INIT_STOCK = 5;
   localparam int PRICE [N_ITEMS] = '{3, 5, 7, 9};

   typedef struct {
      int due;
      int credit;
      int vend;
      int success;
      int fail;
      int mled;
      int reject;
      int change;
      int rled;
      int sold;
      int avail;
   } exp_t;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   int   cycle    = 0;
   int   n_checks = 0;
   int   n_fails  = 0;
   bit   in_reset = 1'b1;
   exp_t sb [$];

   int   m_credit;
   int   m_stock [N_ITEMS];
   int   m_coins [$];
   bit   m_change;

   vending_machine_param_if #(.N_ITEMS(N_ITEMS), .CREDIT_W(CREDIT_W)) bus ();

   vending_machine_param #(
      .N_ITEMS    (N_ITEMS),
      .CREDIT_W   (CREDIT_W),
      .MAX_CREDIT (MAX_CREDIT),
      .PRICES     ({7'd9, 7'd7, 7'd5, 7'd3}),
      .STOCK_W    (STOCK_W),
      .INIT_STOCK (INIT_STOCK)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle = cycle + 1;

   function automatic int segOf(input int d);
      case (d)
         0: return 'h3F;
         1: return 'h06;
         2: return 'h5B;
         3: return 'h4F;
         4: return 'h66;
         5: return 'h6D;
         6: return 'h7D;
         7: return 'h07;
         8: return 'h7F;
         9: return 'h6F;
         default: return 0;
      endcase
   endfunction

   function automatic int coinValue(input logic [3:0] mi);
      case (mi)
         4'b1000: return 10;
         4'b0100: return 5;
         4'b0010: return 2;
         4'b0001: return 1;
         default: return 0;
      endcase
   endfunction

   function automatic int coinOneHot(input int v);
      case (v)
         10: return 8;
         5:  return 4;
         2:  return 2;
         1:  return 1;
         default: return 0;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   task automatic modelReset();
      m_credit = 0;
      m_change = 1'b0;
      m_coins.delete();
      for (int i = 0; i < N_ITEMS; i++) m_stock[i] = INIT_STOCK;
   endtask

   task automatic modelRestock();
      for (int i = 0; i < N_ITEMS; i++) m_stock[i] = INIT_STOCK;
   endtask

   // Predict what the outputs look like after the clock edge that samples these inputs
   task automatic modelStep(input logic [3:0] mi, input logic [N_ITEMS-1:0] by,
                            input bit rf, input bit rs, output exp_t e);
      int v;
      int rem;
      int idx;
      e = '{default: 0};
      if (m_change) begin
         if (m_coins.size() > 0) begin
            v = m_coins.pop_front();
            m_credit -= v;
            e.change = coinOneHot(v);
         end else begin
            m_change = 1'b0;
         end
         if (mi != 0) e.reject = 1;
         if (by != 0) e.fail = 1;
         if (rs) modelRestock();
      end else if (rf) begin
         if (m_credit > 0) begin
            rem = m_credit;
            while (rem > 0) begin
               if (rem >= 10)     v = 10;
               else if (rem >= 5) v = 5;
               else if (rem >= 2) v = 2;
               else               v = 1;
               m_coins.push_back(v);
               rem -= v;
            end
            m_change = 1'b1;
         end
      end else if (mi != 0) begin
         if ($countones(mi) == 1 && m_credit + coinValue(mi) <= MAX_CREDIT) begin
            m_credit += coinValue(mi);
            e.mled = 1;
         end else begin
            e.reject = 1;
         end
      end else if (by != 0) begin
         if ($countones(by) == 1) begin
            idx = 0;
            for (int i = 0; i < N_ITEMS; i++) if (by[i]) idx = i;
            if (m_credit >= PRICE[idx] && m_stock[idx] > 0) begin
               m_credit -= PRICE[idx];
               m_stock[idx]--;
               e.vend    = int'(by);
               e.success = 1;
            end else begin
               e.fail = 1;
            end
         end else begin
            e.fail = 1;
         end
      end else if (rs) begin
         modelRestock();
      end
      e.credit = m_credit;
      e.rled   = m_change ? 1 : 0;
      for (int i = 0; i < N_ITEMS; i++) begin
         if (m_stock[i] == 0) e.sold |= (1 << i);
         if (!m_change && m_credit >= PRICE[i] && m_stock[i] > 0) e.avail |= (1 << i);
      end
   endtask

   // Drive one cycle of inputs and queue the model's prediction for the next negedge
   task automatic applyStimulus(input logic [3:0] mi, input logic [N_ITEMS-1:0] by,
                                input bit rf, input bit rs);
      exp_t e;
      @(negedge clk);
      bus.moneyin = mi;
      bus.buy     = by;
      bus.refund  = rf;
      bus.restock = rs;
      modelStep(mi, by, rf, rs, e);
      e.due = cycle + 1;
      sb.push_back(e);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(4'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic doReset(input int hold);
      @(negedge clk);
      bus.moneyin = '0;
      bus.buy     = '0;
      bus.refund  = 1'b0;
      bus.restock = 1'b0;
      #2;
      reset_n  = 1'b0;
      in_reset = 1'b1;
      sb.delete();
      modelReset();
      #1;
      checkOutput("reset_credit", 32'(bus.credit), 0);
      checkOutput("reset_refund_led", 32'(bus.refund_led), 0);
      checkOutput("reset_change_coin", 32'(bus.change_coin), 0);
      checkOutput("reset_seg_1000", 32'(bus.seg_1000), segOf(0));
      checkOutput("reset_seg_100", 32'(bus.seg_100), segOf(0));
      checkOutput("reset_seg_10", 32'(bus.seg_10), segOf(0));
      checkOutput("reset_seg_1", 32'(bus.seg_1), segOf(0));
      checkOutput("reset_sold_out", 32'(bus.sold_out_led), 0);
      checkOutput("reset_pulses",
                  32'({bus.vend, bus.moneyin_led, bus.coin_reject, bus.buy_success_led, bus.buy_fail_led}), 0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checkOutput("reset_hold_change_coin", 32'(bus.change_coin), 0);
         checkOutput("reset_hold_credit", 32'(bus.credit), 0);
      end
      @(negedge clk);
      reset_n  = 1'b1;
      in_reset = 1'b0;
   endtask

   // Monitor: compare the DUT against whichever prediction is due this cycle
   always @(negedge clk) begin
      exp_t e;
      if (!in_reset && sb.size() > 0 && sb[0].due == cycle) begin
         e = sb.pop_front();
         checkOutput("credit", 32'(bus.credit), e.credit);
         checkOutput("seg_1000", 32'(bus.seg_1000), segOf(e.credit / 10));
         checkOutput("seg_100", 32'(bus.seg_100), segOf(e.credit % 10));
         checkOutput("seg_10", 32'(bus.seg_10), segOf(0));
         checkOutput("seg_1", 32'(bus.seg_1), segOf(0));
         checkOutput("vend", 32'(bus.vend), e.vend);
         checkOutput("buy_success_led", 32'(bus.buy_success_led), e.success);
         checkOutput("buy_fail_led", 32'(bus.buy_fail_led), e.fail);
         checkOutput("moneyin_led", 32'(bus.moneyin_led), e.mled);
         checkOutput("coin_reject", 32'(bus.coin_reject), e.reject);
         checkOutput("change_coin", 32'(bus.change_coin), e.change);
         checkOutput("refund_led", 32'(bus.refund_led), e.rled);
         checkOutput("sold_out_led", 32'(bus.sold_out_led), e.sold);
         checkOutput("buy_available_led", 32'(bus.buy_available_led), e.avail);
      end
   end

   // Hard stop if the run ever stalls
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: directed scenarios, then random traffic
   initial begin
      logic [3:0]         mi;
      logic [N_ITEMS-1:0] by;
      int                 r;
      int                 waited;

      bus.moneyin = '0;
      bus.buy     = '0;
      bus.refund  = 1'b0;
      bus.restock = 1'b0;
      modelReset();
      doReset(2);

      applyStimulus(4'b0100, '0, 1'b0, 1'b0);
      applyStimulus(4'b0010, '0, 1'b0, 1'b0);
      applyStimulus(4'b0001, '0, 1'b0, 1'b0);

      applyStimulus(4'b0001, '0, 1'b0, 1'b0);
      applyStimulus(4'b0010, '0, 1'b0, 1'b0);
      applyStimulus(4'b0001, '0, 1'b0, 1'b0);

      applyStimulus(4'b0, 4'b1000, 1'b0, 1'b0);
      applyStimulus(4'b0, 4'b0001, 1'b0, 1'b0);

      for (int k = 0; k < 5; k++) begin
         applyStimulus(4'b0010, '0, 1'b0, 1'b0);
         applyStimulus(4'b0001, '0, 1'b0, 1'b0);
         applyStimulus(4'b0, 4'b0001, 1'b0, 1'b0);
      end
      applyStimulus(4'b0100, '0, 1'b0, 1'b0);
      applyStimulus(4'b0, 4'b0001, 1'b0, 1'b0);
      applyStimulus(4'b0, '0, 1'b0, 1'b1);

      applyStimulus(4'b0010, '0, 1'b0, 1'b0);
      applyStimulus(4'b0, '0, 1'b1, 1'b0);
      applyStimulus(4'b0001, '0, 1'b0, 1'b0);
      applyStimulus(4'b0, 4'b0010, 1'b1, 1'b0);
      idleCycles(3);

      applyStimulus(4'b0011, '0, 1'b0, 1'b0);
      applyStimulus(4'b0100, '0, 1'b0, 1'b0);
      applyStimulus(4'b0, 4'b0001, 1'b1, 1'b0);
      idleCycles(4);

      applyStimulus(4'b0, 4'b0110, 1'b0, 1'b0);
      applyStimulus(4'b1000, '0, 1'b0, 1'b0);
      applyStimulus(4'b0001, '0, 1'b0, 1'b0);
      applyStimulus(4'b0, '0, 1'b1, 1'b0);
      applyStimulus(4'b0, '0, 1'b0, 1'b0);
      doReset(3);
      idleCycles(2);

      for (int k = 0; k < 400; k++) begin
         mi = '0;
         by = '0;
         r  = $urandom_range(0, 9);
         if (r <= 3) begin
            if ($urandom_range(0, 7) == 0) mi = 4'($urandom_range(1, 15));
            else                           mi = 4'(1 << $urandom_range(0, 3));
            applyStimulus(mi, '0, 1'b0, 1'b0);
         end else if (r <= 6) begin
            if ($urandom_range(0, 7) == 0) by = N_ITEMS'($urandom_range(1, 15));
            else                           by = N_ITEMS'(1 << $urandom_range(0, N_ITEMS-1));
            applyStimulus(4'b0, by, 1'b0, 1'b0);
         end else if (r == 7) begin
            applyStimulus(4'b0, '0, 1'b1, 1'b0);
         end else if (r == 8) begin
            applyStimulus(4'b0, '0, 1'b0, 1'b1);
         end else begin
            applyStimulus(4'b0, '0, 1'b0, 1'b0);
         end
      end

      idleCycles(8);
      waited = 0;
      while (sb.size() > 0 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      if (sb.size() > 0) begin
         n_checks++;
         n_fails++;
         $display("[TB] FAIL scoreboard_drain: %0d predictions left, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
